// File: rtl/ramb4_s1_byte_master_if.sv
// Byte request/response bus between a client and ramb4_s1_byte_master.
//   req_valid/req_ready/req_we/req_addr/req_wdata : byte request handshake
//   rsp_valid/rsp_ready/rsp_rdata                 : read response handshake
// master = client side, slave = byte master side.
interface ramb4_s1_byte_master_if;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ramb4_s1_byte_master.sv
// Serialises byte reads/writes onto a 4096x1 RAM port, one bit per cycle.
//   CLKA     : clock for all logic and the attached RAM port
//   RSTB     : synchronous active-high reset
//   bus      : byte request/response handshake (slave modport)
//   ram_addr : bit address {byte_addr, k}
//   ram_en/ram_we/ram_di : RAM port controls and write bit (registered)
//   ram_rst  : RAM output reset, tied low
//   ram_do   : RAM read bit, valid the cycle after the enabled read edge
// LSB_FIRST=1 stores data bit k at {addr,k}; 0 stores data bit 7-k there.
module ramb4_s1_byte_master #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                          CLKA,
  input  logic                          RSTB,
  ramb4_s1_byte_master_if.slave         bus,
  output logic [11:0]                   ram_addr,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic                          ram_di,
  output logic                          ram_rst,
  input  logic                          ram_do
);
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned K_W    = 3;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t            state_q, state_nxt;
  logic [K_W-1:0]    k_q, k_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [DATA_W-1:0] cap_q, cap_nxt;
  logic              rd_pend_q, rd_pend_nxt;
  logic [K_W-1:0]    rd_idx_q, rd_idx_nxt;
  logic              req_ready_q;
  logic              rsp_valid_q, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic [11:0]       ram_addr_q, ram_addr_nxt;
  logic              ram_en_q, ram_en_nxt;
  logic              ram_we_q, ram_we_nxt;
  logic              ram_di_q, ram_di_nxt;

  // Data-bit position that maps to RAM bit k.
  function automatic logic [K_W-1:0] bit_pos(input logic [K_W-1:0] idx);
    return LSB_FIRST ? idx : K_W'(3'd7 - idx);
  endfunction

  // State and datapath registers.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state_q     <= IDLE;
      k_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cap_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_di_q    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      k_q         <= k_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      cap_q       <= cap_nxt;
      rd_pend_q   <= rd_pend_nxt;
      rd_idx_q    <= rd_idx_nxt;
      req_ready_q <= (state_nxt == IDLE);
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      ram_addr_q  <= ram_addr_nxt;
      ram_en_q    <= ram_en_nxt;
      ram_we_q    <= ram_we_nxt;
      ram_di_q    <= ram_di_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state_q;
    k_nxt         = k_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    cap_nxt       = cap_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_rdata_nxt = rsp_rdata_q;
    ram_addr_nxt  = '0;
    ram_en_nxt    = 1'b0;
    ram_we_nxt    = 1'b0;
    ram_di_nxt    = 1'b0;
    // A read edge this cycle yields ram_do next cycle for that bit.
    rd_pend_nxt   = ram_en_q & ~ram_we_q;
    rd_idx_nxt    = ram_addr_q[K_W-1:0];

    if (rd_pend_q) begin
      cap_nxt[bit_pos(rd_idx_q)] = ram_do;
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_nxt     = bus.req_addr;
          wdata_nxt    = bus.req_wdata;
          k_nxt        = '0;
          ram_en_nxt   = 1'b1;
          ram_we_nxt   = bus.req_we;
          ram_addr_nxt = {bus.req_addr, 3'd0};
          ram_di_nxt   = bus.req_we & bus.req_wdata[bit_pos(3'd0)];
          state_nxt    = bus.req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (k_q == 3'd7) begin
          k_nxt     = '0;
          state_nxt = IDLE;
        end else begin
          k_nxt        = K_W'(k_q + 3'd1);
          ram_en_nxt   = 1'b1;
          ram_we_nxt   = 1'b1;
          ram_addr_nxt = {addr_q, K_W'(k_q + 3'd1)};
          ram_di_nxt   = wdata_q[bit_pos(K_W'(k_q + 3'd1))];
        end
      end
      READ: begin
        if (ram_en_q) begin
          if (k_q == 3'd7) begin
            // Last bit issued; one more cycle to capture it.
            k_nxt = '0;
          end else begin
            k_nxt        = K_W'(k_q + 3'd1);
            ram_en_nxt   = 1'b1;
            ram_addr_nxt = {addr_q, K_W'(k_q + 3'd1)};
          end
        end else begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = cap_nxt;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ram_addr      = ram_addr_q;
  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_di        = ram_di_q;
  assign ram_rst       = 1'b0;
endmodule
